// File: rtl/dmtd_pkg.sv
// dmtd_pkg: shared state encoding, width helpers and error arithmetic for the DMTD phase servo.
package dmtd_pkg;

    typedef enum logic [2:0] {IDLE, CALC, STEP, WAIT_DONE, SETTLE} servo_state_t;

    function automatic int err_w(input int counter_bits);
        return counter_bits + 1;
    endfunction

    function automatic int integ_w(input int counter_bits);
        return counter_bits + 4;
    endfunction

    // Fold a raw phase difference into [-period/2, period/2).
    function automatic logic signed [63:0] wrap_err(input logic signed [63:0] raw, input longint period);
        return raw >= period / 2 ? raw - period : raw < -(period / 2) ? raw + period : raw;
    endfunction

    function automatic logic signed [63:0] clamp_step(input logic signed [63:0] v, input longint lim);
        return v > lim ? lim : v < -lim ? -lim : v;
    endfunction

endpackage

// File: rtl/mmcm_ps_sequencer.sv
// mmcm_ps_sequencer: issues a burst of MMCM phase-shift steps, one ps_en per ps_done, with a per-step timeout.
module mmcm_ps_sequencer
    import dmtd_pkg::*;
#(
    parameter int COUNT_W    = 7,
    parameter int PS_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               dir,
    input  logic [COUNT_W-1:0] count,
    input  logic               ps_done,
    output logic               ps_en,
    output logic               ps_incdec,
    output logic               stepped,
    output logic               finished,
    output logic               timed_out
);

    localparam int TW = $clog2(PS_TIMEOUT + 1);

    servo_state_t       state, state_nx;
    logic [COUNT_W-1:0] remaining;
    logic [TW-1:0]      tmr;

    // An abort only suppresses steps not yet requested; an issued step is always waited out.
    always_comb begin
        state_nx  = state;
        ps_en     = 1'b0;
        stepped   = 1'b0;
        finished  = 1'b0;
        timed_out = 1'b0;
        case (state)
            STEP: begin
                ps_en    = !abort;
                finished = abort;
                state_nx = abort ? IDLE : WAIT_DONE;
            end
            WAIT_DONE: begin
                if (ps_done) begin
                    stepped  = 1'b1;
                    finished = abort || remaining == COUNT_W'(1);
                    state_nx = finished ? IDLE : STEP;
                end else if (tmr == TW'(PS_TIMEOUT - 1)) begin
                    timed_out = 1'b1;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = start ? STEP : IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            tmr       <= '0;
            ps_incdec <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                remaining <= count;
                ps_incdec <= dir;
            end
            if (state == STEP)
                tmr <= '0;
            else if (state == WAIT_DONE)
                tmr <= tmr + 1'b1;
            if (stepped)
                remaining <= remaining - 1'b1;
        end
    end

endmodule

// File: rtl/dmtd_phase_servo.sv
// dmtd_phase_servo: turns DMTD phase measurements into MMCM phase-shift bursts, tracking lock and PS faults.
// Define DMTD_SERVO_INTEGRAL_EN for PI control; otherwise the loop is proportional only.
module dmtd_phase_servo
    import dmtd_pkg::*;
#(
    parameter int COUNTER_BITS  = 28,
    parameter int PERIOD_COUNTS = 16384,
    parameter int KP_SHIFT      = 2,
    parameter int KI_SHIFT      = 4,
    parameter int MAX_STEP      = 64,
    parameter int PS_TIMEOUT    = 1024,
    parameter int LOCK_TOL      = 4,
    parameter int LOCK_CNT      = 8,
    parameter int SETTLE_MEAS   = 1
) (
    input  logic                    clk_sys,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    clear_fault,
    input  logic [COUNTER_BITS-1:0] setpoint,
    input  logic [COUNTER_BITS-1:0] phase_in,
    input  logic                    phase_valid,
    input  logic                    phase_err_in,
    output logic                    ps_en,
    output logic                    ps_incdec,
    input  logic                    ps_done,
    output logic [COUNTER_BITS:0]   err_out,
    output logic [31:0]             shift_total,
    output logic                    busy,
    output logic                    locked,
    output logic                    fault
);

    localparam int ERR_W = err_w(COUNTER_BITS);
    localparam int CW    = $clog2(MAX_STEP + 1);
    localparam int LW    = $clog2(LOCK_CNT + 1);
`ifdef DMTD_SERVO_INTEGRAL_EN
    localparam int     INTEG_W = integ_w(COUNTER_BITS);
    localparam longint IMAX    = (64'sd1 <<< (INTEG_W - 1)) - 64'sd1;
    logic signed [INTEG_W-1:0] integ;
`endif

    servo_state_t            state, state_nx;
    logic [COUNTER_BITS-1:0] phase_q;
    logic [LW-1:0]           lock_cnt;
    logic [7:0]              settle_cnt;
    logic signed [63:0]      err64, integ_new64, corr64;
    logic                    in_tol, start, step_inc;
    logic [CW-1:0]           step_cnt;
    logic                    seq_stepped, seq_fin, seq_to;

    always_comb begin
        err64 = wrap_err($signed(64'(phase_q)) - $signed(64'(setpoint)), longint'(PERIOD_COUNTS));
`ifdef DMTD_SERVO_INTEGRAL_EN
        integ_new64 = 64'(integ) + err64;
        integ_new64 = integ_new64 > IMAX ? IMAX : integ_new64 < -IMAX - 64'sd1 ? -IMAX - 64'sd1 : integ_new64;
`else
        integ_new64 = '0;
`endif
        corr64   = clamp_step((err64 >>> KP_SHIFT) + (integ_new64 >>> KI_SHIFT), longint'(MAX_STEP));
        in_tol   = err64 <= longint'(LOCK_TOL) && err64 >= -longint'(LOCK_TOL);
        step_inc = corr64[63];
        step_cnt = CW'(corr64[63] ? -corr64 : corr64);
        start    = state == CALC && enable && corr64 != '0;
        state_nx = state;
        case (state)
            IDLE:    state_nx = enable && phase_valid && !phase_err_in && !fault ? CALC : IDLE;
            CALC:    state_nx = start ? STEP : IDLE;
            STEP:    state_nx = seq_to ? IDLE : seq_fin ? (enable ? SETTLE : IDLE) : STEP;
            SETTLE:  state_nx = !enable || (phase_valid && settle_cnt == 8'(SETTLE_MEAS - 1)) ? IDLE : SETTLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = state != IDLE;

    mmcm_ps_sequencer #(
        .COUNT_W    (CW),
        .PS_TIMEOUT (PS_TIMEOUT)
    ) u_seq (
        .clk       (clk_sys),
        .rst       (rst),
        .start     (start),
        .abort     (!enable),
        .dir       (step_inc),
        .count     (step_cnt),
        .ps_done   (ps_done),
        .ps_en     (ps_en),
        .ps_incdec (ps_incdec),
        .stepped   (seq_stepped),
        .finished  (seq_fin),
        .timed_out (seq_to)
    );

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            phase_q     <= '0;
            settle_cnt  <= '0;
            err_out     <= '0;
            lock_cnt    <= '0;
            locked      <= 1'b0;
            shift_total <= '0;
            fault       <= 1'b0;
`ifdef DMTD_SERVO_INTEGRAL_EN
            integ       <= '0;
`endif
        end else begin
            state      <= state_nx;
            settle_cnt <= state == SETTLE ? settle_cnt + 8'(phase_valid) : '0;
            if (state == IDLE)
                phase_q <= phase_in;
            if (state == CALC && enable) begin
                err_out  <= ERR_W'(err64);
                lock_cnt <= in_tol ? (lock_cnt == LW'(LOCK_CNT) ? lock_cnt : lock_cnt + 1'b1) : '0;
                locked   <= in_tol && lock_cnt >= LW'(LOCK_CNT - 1);
`ifdef DMTD_SERVO_INTEGRAL_EN
                integ    <= INTEG_W'(integ_new64);
`endif
            end
            if (seq_stepped)
                shift_total <= ps_incdec ? shift_total + 32'd1 : shift_total - 32'd1;
            // Lock loss overrides any in-tolerance update made in the same cycle.
            if (seq_to || phase_err_in || !enable) begin
                lock_cnt <= '0;
                locked   <= 1'b0;
            end
`ifdef DMTD_SERVO_INTEGRAL_EN
            if (!enable)
                integ <= '0;
`endif
            fault <= seq_to || (fault && !clear_fault);
        end
    end

endmodule
